// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution address sequencer: FSM encoding and
// the element-address width derivation.
package cnn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } cnnState_e;

   function automatic int cnnAddrWidth(input int maxSize);
      return (maxSize > 1) ? $clog2(maxSize) : 1;
   endfunction

endpackage

// File: rtl/cnn_conv_addr_gen_if.sv
// Beat bus from the address sequencer to the banked RAMs / MAC.
// Handshake: a beat transfers on a rising clock edge where addrValidOut && addrReadyIn;
// once addrValidOut is high the payload holds stable until that transfer.
interface cnn_conv_addr_gen_if #(
   parameter int VECTOR_SIZE = 8,
   parameter int ADDR_WIDTH  = 12
);
   logic                              addrValidOut;
   logic                              addrReadyIn;
   logic [VECTOR_SIZE*ADDR_WIDTH-1:0] dataAddrOut;
   logic [VECTOR_SIZE*ADDR_WIDTH-1:0] filtAddrOut;
   logic [VECTOR_SIZE-1:0]            laneMaskOut;
   logic                              lastOut;

   modport master (
      output addrValidOut, dataAddrOut, filtAddrOut, laneMaskOut, lastOut,
      input  addrReadyIn
   );

   modport slave (
      input  addrValidOut, dataAddrOut, filtAddrOut, laneMaskOut, lastOut,
      output addrReadyIn
   );
endinterface

// File: rtl/cnn_credit_counter.sv
// Counts output pixels issued but not yet popped from the result FIFO.
// A pop with nothing outstanding is ignored; issue and pop together cancel.
module cnn_credit_counter #(
   parameter int MAX_COUNT = 128,
   localparam int CW = $clog2(MAX_COUNT + 1)
) (
   input  logic          clkIn,
   input  logic          rstIn,
   input  logic          clearIn,
   input  logic          incIn,
   input  logic          decIn,
   output logic [CW-1:0] countOut
);
   logic decEff;

   assign decEff = decIn && (countOut != '0);

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn)                  countOut <= '0;
      else if (clearIn)           countOut <= '0;
      else if (incIn && !decEff)  countOut <= countOut + CW'(1);
      else if (!incIn && decEff)  countOut <= countOut - CW'(1);
   end
endmodule

// File: rtl/cnn_conv_addr_gen.sv
// Valid-mode 2-D convolution address sequencer: walks output pixels, filter rows
// and VECTOR_SIZE-wide column chunks, issuing per-lane data/filter addresses.
module cnn_conv_addr_gen
   import cnn_pkg::*;
#(
   parameter int VECTOR_SIZE = 8,
   parameter int MAX_SIZE    = 4096,
   parameter int DIM_WIDTH   = 13,
   parameter int OUT_CREDITS = 128,
   localparam int ADDR_WIDTH = cnnAddrWidth(MAX_SIZE)
) (
   input  logic                  clkIn,
   input  logic                  rstIn,
   input  logic                  startIn,
   input  logic                  abortIn,
   input  logic [DIM_WIDTH-1:0]  dataRowsIn,
   input  logic [DIM_WIDTH-1:0]  dataColsIn,
   input  logic [DIM_WIDTH-1:0]  filtRowsIn,
   input  logic [DIM_WIDTH-1:0]  filtColsIn,
   input  logic [ADDR_WIDTH-1:0] dataBaseIn,
   input  logic [ADDR_WIDTH-1:0] filtBaseIn,
   cnn_conv_addr_gen_if.master   beat,
   input  logic                  resultPopIn,
   output logic                  busyOut,
   output logic                  doneOut,
   output logic                  errOut
);
   localparam int CRED_W = $clog2(OUT_CREDITS + 1);
   localparam int SUM_W  = DIM_WIDTH + 1;
   localparam logic [SUM_W-1:0]       V_STEP   = SUM_W'(VECTOR_SIZE);
   localparam logic [2*DIM_WIDTH:0]   MAX_EL   = (2*DIM_WIDTH+1)'(MAX_SIZE);
   localparam logic [CRED_W:0]        CRED_MAX = (CRED_W+1)'(OUT_CREDITS);

   cnnState_e state, stateNext;
   logic doneNext, errNext, cfgOk;
   logic [2*DIM_WIDTH-1:0] dataElems, filtElems;
   logic [DIM_WIDTH-1:0] filtRowsQ, filtColsQ, dataColsQ, rowLimQ, colLimQ;
   logic [DIM_WIDTH-1:0] rQ, cQ, frQ, fcQ;
   logic [ADDR_WIDTH-1:0] filtBaseQ, rowBaseQ, pixBaseQ, dRowAddrQ, fRowAddrQ, dColsA, fColsA;
   logic issuedAll, validQ, lastQ, firstQ, finalQ;
   logic accept, loadEn, nextFirst, creditFree, lastChunk, lastRow, lastCol, lastPix;
   logic [VECTOR_SIZE*ADDR_WIDTH-1:0] dataAddrQ, filtAddrQ, laneData, laneFilt;
   logic [VECTOR_SIZE-1:0] maskQ, laneMask;
   logic [SUM_W-1:0] laneOff [VECTOR_SIZE];
   logic [CRED_W-1:0] outstanding;

   assign dataElems = {{DIM_WIDTH{1'b0}}, dataRowsIn} * {{DIM_WIDTH{1'b0}}, dataColsIn};
   assign filtElems = {{DIM_WIDTH{1'b0}}, filtRowsIn} * {{DIM_WIDTH{1'b0}}, filtColsIn};
   assign cfgOk = (dataRowsIn != '0) && (dataColsIn != '0) && (filtRowsIn != '0) &&
                  (filtColsIn != '0) && (filtRowsIn <= dataRowsIn) && (filtColsIn <= dataColsIn) &&
                  ({1'b0, dataElems} <= MAX_EL) && ({1'b0, filtElems} <= MAX_EL);

   assign dColsA    = ADDR_WIDTH'(dataColsQ);
   assign fColsA    = ADDR_WIDTH'(filtColsQ);
   assign lastChunk = ({1'b0, fcQ} + V_STEP) >= {1'b0, filtColsQ};
   assign lastRow   = (frQ == filtRowsQ - DIM_WIDTH'(1));
   assign lastCol   = (cQ == colLimQ);
   assign lastPix   = (rQ == rowLimQ);
   assign nextFirst = (frQ == '0) && (fcQ == '0);

   // A first beat sitting unaccepted in the output register already owns a credit.
   assign creditFree = ({1'b0, outstanding} + (CRED_W+1)'(validQ && firstQ)) < CRED_MAX;
   assign accept     = validQ && beat.addrReadyIn;
   assign loadEn     = (state == ST_RUN) && !issuedAll && (!validQ || beat.addrReadyIn) &&
                       (!nextFirst || creditFree);

   always_comb begin
      laneOff  = '{default: '0};
      laneData = '0;
      laneFilt = '0;
      laneMask = '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
         laneOff[i] = {1'b0, fcQ} + SUM_W'(i);
         if (laneOff[i] < {1'b0, filtColsQ}) begin
            laneMask[i] = 1'b1;
            laneData[i*ADDR_WIDTH +: ADDR_WIDTH] = dRowAddrQ + ADDR_WIDTH'(laneOff[i]);
            laneFilt[i*ADDR_WIDTH +: ADDR_WIDTH] = fRowAddrQ + ADDR_WIDTH'(laneOff[i]);
         end
      end
   end

   always_comb begin
      stateNext = state;
      doneNext  = 1'b0;
      errNext   = 1'b0;
      if (abortIn) stateNext = ST_IDLE;
      else begin
         case (state)
            ST_IDLE:  if (startIn) begin
                         if (cfgOk) stateNext = ST_RUN;
                         else       errNext   = 1'b1;
                      end
            ST_RUN:   if (accept && finalQ) stateNext = ST_DRAIN;
            ST_DRAIN: if (outstanding == '0) begin
                         stateNext = ST_IDLE;
                         doneNext  = 1'b1;
                      end
            default:  stateNext = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state   <= ST_IDLE;
         doneOut <= 1'b0;
         errOut  <= 1'b0;
      end else begin
         state   <= stateNext;
         doneOut <= doneNext;
         errOut  <= errNext;
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         {filtRowsQ, filtColsQ, dataColsQ, rowLimQ, colLimQ} <= '0;
         {rQ, cQ, frQ, fcQ} <= '0;
         {filtBaseQ, rowBaseQ, pixBaseQ, dRowAddrQ, fRowAddrQ} <= '0;
         {dataAddrQ, filtAddrQ, maskQ} <= '0;
         {validQ, lastQ, firstQ, finalQ} <= '0;
         issuedAll <= 1'b1;
      end else if (abortIn) begin
         validQ    <= 1'b0;
         issuedAll <= 1'b1;
      end else if (state == ST_IDLE) begin
         validQ <= 1'b0;
         if (startIn && cfgOk) begin
            filtRowsQ <= filtRowsIn;
            filtColsQ <= filtColsIn;
            dataColsQ <= dataColsIn;
            rowLimQ   <= dataRowsIn - filtRowsIn;
            colLimQ   <= dataColsIn - filtColsIn;
            {rQ, cQ, frQ, fcQ} <= '0;
            filtBaseQ <= filtBaseIn;
            fRowAddrQ <= filtBaseIn;
            rowBaseQ  <= dataBaseIn;
            pixBaseQ  <= dataBaseIn;
            dRowAddrQ <= dataBaseIn;
            issuedAll <= 1'b0;
         end
      end else begin
         if (accept) validQ <= 1'b0;
         if (loadEn) begin
            validQ    <= 1'b1;
            dataAddrQ <= laneData;
            filtAddrQ <= laneFilt;
            maskQ     <= laneMask;
            lastQ     <= lastChunk && lastRow;
            firstQ    <= nextFirst;
            finalQ    <= lastChunk && lastRow && lastCol && lastPix;
            // Row bases advance by additions only; wrap is modulo 2^ADDR_WIDTH.
            if (!lastChunk) fcQ <= fcQ + DIM_WIDTH'(VECTOR_SIZE);
            else begin
               fcQ <= '0;
               if (!lastRow) begin
                  frQ       <= frQ + DIM_WIDTH'(1);
                  dRowAddrQ <= dRowAddrQ + dColsA;
                  fRowAddrQ <= fRowAddrQ + fColsA;
               end else begin
                  frQ       <= '0;
                  fRowAddrQ <= filtBaseQ;
                  if (!lastCol) begin
                     cQ        <= cQ + DIM_WIDTH'(1);
                     pixBaseQ  <= pixBaseQ + ADDR_WIDTH'(1);
                     dRowAddrQ <= pixBaseQ + ADDR_WIDTH'(1);
                  end else begin
                     cQ <= '0;
                     if (!lastPix) begin
                        rQ        <= rQ + DIM_WIDTH'(1);
                        rowBaseQ  <= rowBaseQ + dColsA;
                        pixBaseQ  <= rowBaseQ + dColsA;
                        dRowAddrQ <= rowBaseQ + dColsA;
                     end else issuedAll <= 1'b1;
                  end
               end
            end
         end
      end
   end

   cnn_credit_counter #(.MAX_COUNT(OUT_CREDITS)) uCredit (
      .clkIn    (clkIn),
      .rstIn    (rstIn),
      .clearIn  (abortIn),
      .incIn    (accept && firstQ),
      .decIn    (resultPopIn),
      .countOut (outstanding)
   );

   assign beat.addrValidOut = validQ;
   assign beat.dataAddrOut  = dataAddrQ;
   assign beat.filtAddrOut  = filtAddrQ;
   assign beat.laneMaskOut  = maskQ;
   assign beat.lastOut      = lastQ;
   assign busyOut           = (state != ST_IDLE);
endmodule
